serial_sub_ctrl: RTL

//   Sequencer that performs a WIDTH-bit unsigned subtraction a - b bit-serially, LSB first.
//   It reuses one subtract cell: two half-subtractor stages plus a borrow OR (a full-subtractor slice).
//   A start/busy/done handshake drives it, and it registers the full difference and final borrow.
//   It sits between a requester issuing operand pairs and downstream logic consuming results.

---
 rtl/serial_sub_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned subtractor (a - b), LSB first.
// One full-subtractor slice is reused for WIDTH cycles per operation. A
// start/busy/done handshake sequences it. The difference and the final
// borrow are registered and held until the next completion.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    // Only WIDTH-1 partial result bits need storing. The last bit goes
    // straight from the cell into diff_reg on the final edge.
    logic [WIDTH-2:0] res_sh_reg;
    logic             bin_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;

    logic             accept;
    logic             last_bit;

    // Subtract cell: two half-subtractors plus a borrow OR.
    logic             hs1_d;
    logic             hs1_b;
    logic             cell_d;
    logic             hs2_b;
    logic             cell_bout;
    logic [WIDTH-1:0] res_cat;

    // Operand bit 0 and the running borrow go through the full-subtractor slice.
    always_comb begin
        hs1_d     = a_sh_reg[0] ^ b_sh_reg[0];
        hs1_b     = ~a_sh_reg[0] & b_sh_reg[0];
        cell_d    = hs1_d ^ bin_reg;
        hs2_b     = ~hs1_d & bin_reg;
        cell_bout = hs1_b | hs2_b;
        res_cat   = {cell_d, res_sh_reg};
    end

    // A new op may start whenever no op is running, including in DONE.
    assign accept   = start && (state_reg != RUN);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and status outputs decoded from the state.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then shift one bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            bin_reg    <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg    <= '0;
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            res_sh_reg <= '0;
            bin_reg    <= 1'b0;
        end else if (state_reg == RUN) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            res_sh_reg <= res_cat[WIDTH-1:1];
            bin_reg    <= cell_bout;
            if (last_bit) begin
                // Publish the result only at completion so diff holds during RUN.
                diff_reg   <= res_cat;
                borrow_reg <= cell_bout;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;

endmodule
